data_mem_responder: RTL



---
 rtl/data_mem_responder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the processor's data-memory port.
// Holds 2^DEPTH_LOG2 doublewords and serves one load/store at a time over a
// valid/ready handshake. Loads return the whole aligned doubleword; sub-word
// stores are a read-merge-write. A request is decoded and captured at the
// handshake edge and walks IDLE -> RD -> (WR) -> RESP -> IDLE.
// Build option: define MISALIGN_TRAP_EN to reject misaligned accesses. When
// it is undefined, the byte offset is forced down to the natural alignment.
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int READ_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [2:0]            off_q, off_d;
  logic [7:0]            bmask_q, bmask_d;
  logic [63:0]           wdata_q, wdata_d;

  // Storage and its registered read port (no reset on either).
  logic [63:0] mem [2**DEPTH_LOG2];
  logic [63:0] word_q;

  logic        hs;
  logic        rd_en;
  logic [7:0]  nb_mask;
  logic [2:0]  align;
  logic [2:0]  off_in;
  logic [7:0]  bmask_in;
  logic        req_illegal;
  logic [63:0] wshift;
  logic [63:0] merged;

  assign hs    = req_valid & req_ready;
  assign rd_en = (state_q == S_RD) & ~err_q & (cnt_q == 3'd0);

  // Per-size byte-lane mask (right-justified) and low-address alignment bits.
  always_comb begin
    nb_mask = 8'hFF;
    align   = 3'd0;
    case (req_size)
      3'd0:    begin nb_mask = 8'hFF; align = 3'd7; end
      3'd1:    begin nb_mask = 8'h0F; align = 3'd3; end
      3'd2:    begin nb_mask = 8'h03; align = 3'd1; end
      3'd3:    begin nb_mask = 8'h01; align = 3'd0; end
      default: begin nb_mask = 8'hFF; align = 3'd0; end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  // Misaligned offsets are rejected, so the raw offset is kept as-is.
  assign off_in      = req_addr[2:0];
  assign req_illegal = req_size[2] | (|req_addr[63:DEPTH_LOG2+3]) |
                       (|(req_addr[2:0] & align));
`else
  // Misaligned offsets are silently rounded down to the access size.
  assign off_in      = req_addr[2:0] & ~align;
  assign req_illegal = req_size[2] | (|req_addr[63:DEPTH_LOG2+3]);
`endif

  assign bmask_in = nb_mask << off_in;

  // Place the right-justified store data onto its byte lanes.
  assign wshift = req_wdata_shift(wdata_q, off_q);

  function automatic logic [63:0] req_wdata_shift(input logic [63:0] d,
                                                  input logic [2:0]  o);
    return d << {o, 3'b000};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = bmask_q[gi] ? wshift[gi*8 +: 8]
                                             : word_q[gi*8 +: 8];
    end
  endgenerate

  // Next-state logic: capture on handshake, count read latency, sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    err_d   = err_q;
    idx_d   = idx_q;
    off_d   = off_q;
    bmask_d = bmask_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          state_d = S_RD;
          cnt_d   = 3'(READ_LAT);
          write_d = req_write;
          err_d   = req_illegal;
          idx_d   = req_addr[DEPTH_LOG2+2:3];
          off_d   = off_in;
          bmask_d = bmask_in;
          wdata_d = req_wdata;
        end
      end
      S_RD: begin
        // A rejected request skips the memory and answers next cycle.
        if (err_q) begin
          state_d = S_RESP;
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = write_q ? S_WR : S_RESP;
        end
      end
      S_WR:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and capture registers; reset drops any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      off_q   <= 3'd0;
      bmask_q <= 8'd0;
      wdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      bmask_q <= bmask_d;
      wdata_q <= wdata_d;
    end
  end

  // Memory: latch the word at RD exit, commit the merged word at WR exit.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      word_q <= mem[idx_q];
    end
    if (state_q == S_WR) begin
      mem[idx_q] <= merged;
    end
  end

  assign req_ready = (state_q == S_IDLE) & ~rst;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid & ~err_q & ~write_q) ? word_q : 64'd0;

endmodule
